prescaled_counter: RTL and testbench
====================================

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have parameter TICK_CYCLES, default 125000000, giving enabled clk cycles per count step (1 s at 8 ns period); legal range is 1 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ce, input, 1 bit: count enable; the prescaler advances only while ce=1.
REQ-006 The block SHALL have port up, input, 1 bit: count direction, 1=increment, 0=decrement.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous clear of count and prescaler.
REQ-008 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 The block SHALL have port load_value, input, WIDTH bits: value captured on load.
REQ-010 The block SHALL have port count, output, WIDTH bits: registered counter value, e.g. for LEDS.
REQ-011 The block SHALL have port tick, output, 1 bit: registered one-cycle pulse per prescaler expiry.
REQ-012 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse when a step crosses a boundary (max to 0 up, 0 to max down).

Function
REQ-013 The prescaler SHALL count 0..TICK_CYCLES-1 on each cycle with ce=1, return to 0 on the cycle after TICK_CYCLES-1, and hold its value while ce=0.
REQ-014 An expiry (prescaler==TICK_CYCLES-1, ce=1, no clear/load) SHALL step count and assert tick on the same edge; count SHALL change exactly once per TICK_CYCLES enabled cycles.
REQ-015 A step SHALL add 1 when up=1 and subtract 1 when up=0, modulo 2^WIDTH; up SHALL be sampled at the step edge, and a direction change SHALL NOT reset the prescaler.
REQ-016 wrap SHALL assert on the stepping edge when up=1 and count==2^WIDTH-1, or up=0 and count==0; otherwise wrap=0.
REQ-017 Priority SHALL be clear > load > step; clear zeroes count and prescaler; load sets count=load_value and prescaler=0; neither asserts tick or wrap.
REQ-018 clear and load SHALL act regardless of ce.
REQ-019 For TICK_CYCLES=1, tick SHALL assert on every cycle with ce=1, and count SHALL step each such cycle.
REQ-020 tick and wrap SHALL be 0 in every cycle not covered by REQ-014/REQ-016.

Reset
REQ-021 rst_n=0 SHALL immediately force count=0, prescaler=0, tick=0 and wrap=0, independent of clk, including mid-period; counting SHALL resume from prescaler 0 on the first clk edge after deassertion.

Configuration
REQ-022 Macro PRESCALED_COUNTER_SATURATE_EN SHALL select saturation: when defined, a step at the boundary (up at max, or down at 0) SHALL hold count and pulse wrap; when undefined, count SHALL wrap per REQ-015.

Structure
REQ-023 A shared package counter_pkg SHALL hold the default TICK_CYCLES (125000000), the default WIDTH and the $clog2-based prescaler width helper.
REQ-024 The prescaler SHALL be a sub-module tick_gen (parameter TICK_CYCLES; ports clk, rst_n, ce, restart, tick); count, direction and saturation logic SHALL stay in prescaled_counter.

Verification
REQ-025 Bench cases (TICK_CYCLES=4, WIDTH=4 unless stated):
- ce=1 and up=1 held for 16 cycles -> count 1,2,3,4 at cycles 4,8,12,16, with tick pulsing on exactly those edges.
- Count at 15, up=1, one period -> count=0 and wrap=1 for one cycle; with SATURATE_EN -> count=15 and wrap=1.
- ce toggled 1,0,0,1,1,1 -> step only after 4 enabled cycles; prescaler holds across ce=0.
- load=1 with load_value=9 and clear=1 in the same cycle -> count=0 (clear wins); load only -> count=9, and the next step occurs 4 enabled cycles later.
- Count at 0, up=0 -> count=15 and wrap=1 (wrap mode).
- rst_n pulsed low mid-period at count=7 -> count=0 immediately and the first step occurs 4 cycles after release; TICK_CYCLES=1 run -> a step on every enabled cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared defaults and sizing helper for the prescaled counter family.
package counter_pkg;

  localparam int DEFAULT_WIDTH       = 4;
  localparam int DEFAULT_TICK_CYCLES = 125000000;  // 1 s at an 8 ns clock

  // Prescaler register width; never below 1 so TICK_CYCLES=1 still gets a register.
  function automatic int presc_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles 0..TICK_CYCLES-1 and flags the expiry cycle.
module tick_gen
  import counter_pkg::*;
#(
  parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic restart,
  output logic tick
);

  localparam int PW = presc_width(TICK_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0] presc_reg;
  logic          at_last;

  assign at_last = (presc_reg == LAST);
  // Combinational expiry; the parent registers it alongside the count step.
  assign tick    = ce && at_last && !restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (restart) begin
      presc_reg <= '0;
    end else if (ce) begin
      presc_reg <= at_last ? '0 : presc_reg + PW'(1);
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Up/down counter stepped once per prescaler period, with clear/load and wrap pulse.
// Define PRESCALED_COUNTER_SATURATE_EN to hold at the boundary instead of wrapping.
module prescaled_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);

  logic             step_en;
  logic             boundary;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] stepped;
  logic             tick_reg;
  logic             wrap_reg;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .restart (clear | load),
    .tick    (step_en)
  );

  assign boundary = up ? (count_reg == '1) : (count_reg == '0);

  always_comb begin
    stepped = up ? count_reg + WIDTH'(1) : count_reg - WIDTH'(1);
`ifdef PRESCALED_COUNTER_SATURATE_EN
    if (boundary) begin
      stepped = count_reg;
    end
`endif
  end

  // clear beats load beats step; step_en already excludes clear/load cycles.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = load_value;
    end else if (step_en) begin
      count_next = stepped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      tick_reg  <= step_en;
      wrap_reg  <= step_en && boundary;
    end
  end

  assign count = count_reg;
  assign tick  = tick_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_prescaled_counter.sv
// Table-driven scoreboard bench: TICK_CYCLES=4 and TICK_CYCLES=1 instances, WIDTH=4.
module tb_prescaled_counter;

`ifdef PRESCALED_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    bit       sel;
    bit       ce;
    bit       up;
    bit       clr;
    bit       ld;
    logic [3:0] lv;
    logic [3:0] ecount;
    bit       etick;
    bit       ewrap;
    string    name;
  } vec_t;

  typedef struct {
    string    name;
    bit       sel;
    logic [3:0] count;
    bit       tick;
    bit       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce_a = 1'b0, up_a = 1'b1, clear_a = 1'b0, load_a = 1'b0;
  logic [3:0] lv_a = '0;
  logic [3:0] count_a;
  logic       tick_a, wrap_a;
  logic       ce_b = 1'b0, up_b = 1'b1, clear_b = 1'b0, load_b = 1'b0;
  logic [3:0] lv_b = '0;
  logic [3:0] count_b;
  logic       tick_b, wrap_b;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  prescaled_counter #(.WIDTH(4), .TICK_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce_a), .up(up_a), .clear(clear_a),
    .load(load_a), .load_value(lv_a), .count(count_a), .tick(tick_a), .wrap(wrap_a)
  );

  prescaled_counter #(.WIDTH(4), .TICK_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce_b), .up(up_b), .clear(clear_b),
    .load(load_b), .load_value(lv_b), .count(count_b), .tick(tick_b), .wrap(wrap_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit sel, input bit ce, input bit up, input bit clr, input bit ld,
                     input logic [3:0] lv, input logic [3:0] ec, input bit et, input bit ew,
                     input string name);
    vec_t v;
    v.sel = sel; v.ce = ce; v.up = up; v.clr = clr; v.ld = ld; v.lv = lv;
    v.ecount = ec; v.etick = et; v.ewrap = ew; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one vector, queue its expectation, then compare one edge later.
  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    ce_a = 1'b0; clear_a = 1'b0; load_a = 1'b0;
    ce_b = 1'b0; clear_b = 1'b0; load_b = 1'b0;
    if (v.sel == 1'b0) begin
      ce_a = v.ce; up_a = v.up; clear_a = v.clr; load_a = v.ld; lv_a = v.lv;
    end else begin
      ce_b = v.ce; up_b = v.up; clear_b = v.clr; load_b = v.ld; lv_b = v.lv;
    end
    e.name = v.name; e.sel = v.sel; e.count = v.ecount; e.tick = v.etick; e.wrap = v.ewrap;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (got.sel == 1'b0) begin
      check({got.name, ".count"}, int'(count_a), int'(got.count));
      check({got.name, ".tick"}, int'(tick_a), int'(got.tick));
      check({got.name, ".wrap"}, int'(wrap_a), int'(got.wrap));
    end else begin
      check({got.name, ".count"}, int'(count_b), int'(got.count));
      check({got.name, ".tick"}, int'(tick_b), int'(got.tick));
      check({got.name, ".wrap"}, int'(wrap_b), int'(got.wrap));
    end
    $display("vec %-18s sel=%0d count=%0d tick=%0d wrap=%0d", v.name, v.sel,
             (v.sel ? count_b : count_a), (v.sel ? tick_b : tick_a), (v.sel ? wrap_b : wrap_a));
  endtask

  task automatic run_all();
    foreach (vecs[i]) run_vec(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    // Reset state while rst_n is held low.
    #12;
    check("reset.count", int'(count_a), 0);
    check("reset.tick", int'(tick_a), 0);
    check("reset.wrap", int'(wrap_a), 0);
    check("reset1.count", int'(count_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Steady count-up: one step per 4 enabled cycles.
    for (int i = 1; i <= 16; i++)
      add(0, 1, 1, 0, 0, 0, 4'(i / 4), (i % 4) == 0, 0, "count_up");
    // Wrap (or saturate) at max going up.
    add(0, 0, 1, 0, 1, 15, 15, 0, 0, "load15");
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 15, 0, 0, "pre_wrap_up");
    add(0, 1, 1, 0, 0, 0, SAT ? 4'd15 : 4'd0, 1, 1, "wrap_up");
    add(0, 0, 1, 0, 0, 0, SAT ? 4'd15 : 4'd0, 0, 0, "wrap_one_cycle");
    // Prescaler holds across ce=0.
    add(0, 0, 1, 0, 1, 5, 5, 0, 0, "load5");
    add(0, 1, 1, 0, 0, 0, 5, 0, 0, "ce_gap");
    add(0, 0, 1, 0, 0, 0, 5, 0, 0, "ce_gap");
    add(0, 0, 1, 0, 0, 0, 5, 0, 0, "ce_gap");
    add(0, 1, 1, 0, 0, 0, 5, 0, 0, "ce_gap");
    add(0, 1, 1, 0, 0, 0, 5, 0, 0, "ce_gap");
    add(0, 1, 1, 0, 0, 0, 6, 1, 0, "ce_gap_step");
    // Clear beats load; load restarts the prescaler; load beats a step.
    add(0, 1, 1, 1, 1, 9, 0, 0, 0, "clear_wins");
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, "post_clear");
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, "post_clear");
    add(0, 1, 1, 0, 1, 9, 9, 0, 0, "load9");
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 9, 0, 0, "after_load");
    add(0, 1, 1, 0, 0, 0, 10, 1, 0, "load_then_step");
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 10, 0, 0, "pre_expiry");
    add(0, 1, 1, 0, 1, 3, 3, 0, 0, "load_beats_step");
    // Wrap (or saturate) at 0 going down.
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, "clear");
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0, 0, 0, "pre_wrap_down");
    add(0, 1, 0, 0, 0, 0, SAT ? 4'd0 : 4'd15, 1, 1, "wrap_down");
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, SAT ? 4'd0 : 4'd15, 0, 0, "hold_down");
    add(0, 1, 0, 0, 0, 0, SAT ? 4'd0 : 4'd14, 1, SAT, "after_wrap_down");
    // Direction change mid-period keeps the prescaler phase.
    add(0, 0, 1, 0, 1, 8, 8, 0, 0, "load8");
    add(0, 1, 1, 0, 0, 0, 8, 0, 0, "dir_change");
    add(0, 1, 1, 0, 0, 0, 8, 0, 0, "dir_change");
    add(0, 1, 0, 0, 0, 0, 8, 0, 0, "dir_change");
    add(0, 1, 0, 0, 0, 0, 7, 1, 0, "dir_change_step");
    add(0, 1, 1, 0, 0, 0, 7, 0, 0, "mid_period");
    add(0, 1, 1, 0, 0, 0, 7, 0, 0, "mid_period");
    run_all();

    // Asynchronous reset mid-period at count=7.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset.count", int'(count_a), 0);
    check("async_reset.tick", int'(tick_a), 0);
    check("async_reset.wrap", int'(wrap_a), 0);
    $display("async reset mid-period: count=%0d", count_a);
    ce_a = 1'b1;
    @(posedge clk);
    #1;
    check("reset_held.count", int'(count_a), 0);
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++)
      add(0, 1, 1, 0, 0, 0, (i == 4) ? 4'd1 : 4'd0, i == 4, 0, "post_reset");

    // TICK_CYCLES=1: a step on every enabled cycle.
    add(1, 1, 1, 0, 0, 0, 1, 1, 0, "tc1_step");
    add(1, 1, 1, 0, 0, 0, 2, 1, 0, "tc1_step");
    add(1, 1, 1, 0, 0, 0, 3, 1, 0, "tc1_step");
    add(1, 0, 1, 0, 0, 0, 3, 0, 0, "tc1_idle");
    add(1, 1, 0, 0, 0, 0, 2, 1, 0, "tc1_down");
    add(1, 1, 1, 0, 1, 15, 15, 0, 0, "tc1_load15");
    add(1, 1, 1, 0, 0, 0, SAT ? 4'd15 : 4'd0, 1, 1, "tc1_wrap");
    add(1, 1, 0, 1, 0, 0, 0, 0, 0, "tc1_clear");
    run_all();

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
